// File: rtl/gardner_ted_iq_pkg.sv
// Shared types and helpers for the Gardner timing-error detector.
//   ted_min_out_bits(w) : narrowest output width that can hold the error term
//                         for w-bit signed inputs without overflow.
//   s1_ctrl_t           : stage-1 control bits (valid, trigger, iq mode).
package gardner_ted_pkg;

  // Two (w+1)x(w)-bit products summed: 2w+1 bits each, plus one for the sum.
  function automatic int ted_min_out_bits(input int w);
    return 2 * w + 2;
  endfunction

  typedef struct packed {
    logic valid;
    logic trig;
    logic mode;
  } s1_ctrl_t;

endpackage

// File: rtl/gardner_ted_iq_if.sv
// Sample-in / error-out bundle for gardner_ted_iq.
//   in_i/in_q, in_valid, trigger, iq_mode : sample side (no backpressure)
//   out, out_valid, out_ready, overrun    : result side with valid/ready
// master = producer/consumer around the detector, slave = the detector.
interface gardner_ted_iq_if #(
  parameter int W   = 12,
  parameter int OLB = 26
);
  logic signed [W-1:0]   in_i;
  logic signed [W-1:0]   in_q;
  logic                  in_valid;
  logic                  trigger;
  logic                  iq_mode;
  logic signed [OLB-1:0] out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overrun;

  modport master (
    output in_i, in_q, in_valid, trigger, iq_mode, out_ready,
    input  out, out_valid, overrun
  );

  modport slave (
    input  in_i, in_q, in_valid, trigger, iq_mode, out_ready,
    output out, out_valid, overrun
  );
endinterface

// File: rtl/gardner_ted_iq_delay_line.sv
// Shift-on-enable sample history with three taps.
//   clk, rst   : clock, async active-low reset (clears history)
//   en_i       : shift din_i in
//   din_i      : newest sample x[n]
//   tap0_o     : x[n]            (combinational pass-through)
//   tapmid_o   : x[n-Depth/2]
//   tapend_o   : x[n-Depth]
module sample_delay_line #(
  parameter int Depth = 4,
  parameter int Width = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic signed [Width-1:0] din_i,
  output logic signed [Width-1:0] tap0_o,
  output logic signed [Width-1:0] tapmid_o,
  output logic signed [Width-1:0] tapend_o
);
  // hist_q[k] holds x[n-k] relative to the sample currently on din_i.
  logic [Depth:1][Width-1:0] hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      hist_q <= '0;
    else if (en_i) hist_q <= {hist_q[Depth-1:1], din_i};
  end

  assign tap0_o   = din_i;
  assign tapmid_o = $signed(hist_q[Depth/2]);
  assign tapend_o = $signed(hist_q[Depth]);
endmodule

// File: rtl/gardner_ted_iq.sv
// Gardner timing-error detector, complex baseband.
//   e = I[n-S/2]*(I[n-S]-I[n]) + Q[n-S/2]*(Q[n-S]-Q[n])   (Q term gated by iq_mode)
// Two pipeline stages: stage 1 registers differences/mid taps, stage 2 multiplies,
// sums and loads the output register. Result of a sample accepted at edge k is
// visible after edge k+1.
//   clk, rst : clock, async active-low reset
//   bus      : gardner_ted_iq_if.slave (samples in, error out with valid/ready/overrun)
module gardner_ted_iq
  import gardner_ted_pkg::*;
#(
  parameter int SamplesPerSymbol = 4,
  parameter int InputLengthBits  = 12,
  parameter int OutputLengthBits = 26
) (
  input  logic             clk,
  input  logic             rst,
  gardner_ted_iq_if.slave  bus
);
  localparam int S  = SamplesPerSymbol;
  localparam int W  = InputLengthBits;
  localparam int PW = 2 * W + 1;
  localparam int SW = 2 * W + 2;

  if (S < 2 || (S % 2) != 0) begin : g_bad_sps
    $error("gardner_ted_iq: SamplesPerSymbol must be even and >= 2");
  end
  if (OutputLengthBits < ted_min_out_bits(W)) begin : g_bad_olb
    $error("gardner_ted_iq: OutputLengthBits must be >= 2*InputLengthBits+2");
  end

  typedef struct packed {
    logic signed [W:0]   d_i;
    logic signed [W:0]   d_q;
    logic signed [W-1:0] m_i;
    logic signed [W-1:0] m_q;
    s1_ctrl_t            ctl;
  } s1_t;

  logic signed [W-1:0] i_now, i_mid, i_end;
  logic signed [W-1:0] q_now, q_mid, q_end;

  sample_delay_line #(.Depth(S), .Width(W)) u_dl_i (
    .clk(clk), .rst(rst), .en_i(bus.in_valid), .din_i(bus.in_i),
    .tap0_o(i_now), .tapmid_o(i_mid), .tapend_o(i_end)
  );

  sample_delay_line #(.Depth(S), .Width(W)) u_dl_q (
    .clk(clk), .rst(rst), .en_i(bus.in_valid), .din_i(bus.in_q),
    .tap0_o(q_now), .tapmid_o(q_mid), .tapend_o(q_end)
  );

  // ---- stage 1 ----
  s1_t s1_q, s1_d;

  always_comb begin
    s1_d           = s1_q;
    s1_d.ctl.valid = bus.in_valid;
    s1_d.ctl.trig  = bus.trigger;
    s1_d.ctl.mode  = bus.iq_mode;
    if (bus.in_valid) begin
      // W+1 bits: difference of two W-bit signed values cannot overflow.
      s1_d.d_i = (W+1)'(i_end) - (W+1)'(i_now);
      s1_d.d_q = (W+1)'(q_end) - (W+1)'(q_now);
      s1_d.m_i = i_mid;
      s1_d.m_q = q_mid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s1_q <= '0;
    else      s1_q <= s1_d;
  end

  // ---- stage 2 ----
  logic signed [W:0]                d_i, d_q;
  logic signed [W-1:0]              m_i, m_q;
  logic signed [PW-1:0]             p_i, p_q;
  logic signed [SW-1:0]             sum;
  logic signed [OutputLengthBits-1:0] out_q, out_d;
  logic                             out_valid_q, out_valid_d;
  logic                             overrun_q, overrun_d;
  logic                             wr;

  assign d_i = s1_q.d_i;
  assign d_q = s1_q.d_q;
  assign m_i = s1_q.m_i;
  assign m_q = s1_q.m_q;
  assign wr  = s1_q.ctl.valid;

  always_comb begin
    p_i = PW'(d_i) * PW'(m_i);
    p_q = s1_q.ctl.mode ? PW'(d_q) * PW'(m_q) : '0;
    sum = SW'(p_i) + SW'(p_q);

    out_d       = out_q;
    out_valid_d = out_valid_q;
    // Every accepted sample counts as a write, triggered or not; only
    // triggered ones carry a new error value.
    if (wr) begin
      out_valid_d = 1'b1;
      if (s1_q.ctl.trig) out_d = OutputLengthBits'(sum);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    overrun_d = wr && out_valid_q && !bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_gardner_ted_iq.sv
// Directed bench for gardner_ted_iq (S=4, W=12, OLB=26).
module tb_gardner_ted_iq;
  localparam int S = 4, W = 12, OLB = 26;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gardner_ted_iq_if #(.W(W), .OLB(OLB)) bus();

  gardner_ted_iq #(
    .SamplesPerSymbol(S), .InputLengthBits(W), .OutputLengthBits(OLB)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  longint E_STEP_I[6]  = '{0, 0, -4190209, -4190209, 0, 0};
  longint E_STEP_IQ[6] = '{0, 0, -8380418, -8380418, 0, 0};
  longint E_WORST[6]   = '{0, 0, -8388608, -8388608, 0, 16773120};

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int q, input logic trig, input logic mode);
    bus.in_i     = W'(i);
    bus.in_q     = W'(q);
    bus.trigger  = trig;
    bus.iq_mode  = mode;
    bus.in_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // qsel: 0 -> Q=0, 1 -> Q=I, 2 -> Q=-I. First n0 samples take v0, then v1.
  task automatic step_seq(input string tag, input int n0, input int v0, input int v1,
                          input int qsel, input logic mode, input longint e[6]);
    int v, q;
    do_reset();
    for (int j = 0; j < 7; j++) begin
      v = (j < n0) ? v0 : v1;
      q = (qsel == 0) ? 0 : (qsel == 1) ? v : -v;
      send(v, q, 1'b1, mode);
      if (j == 0) chk({tag, "_lat"}, bus.out_valid, 0);
      else begin
        chk($sformatf("%s[%0d]", tag, j-1), $signed(bus.out), e[j-1]);
        chk({tag, "_vld"}, bus.out_valid, 1);
        chk({tag, "_ovr"}, bus.overrun, 0);
      end
    end
  endtask

  initial begin
    int ovr_cnt;
    bus.in_i = '0; bus.in_q = '0; bus.in_valid = 1'b0;
    bus.trigger = 1'b1; bus.iq_mode = 1'b1; bus.out_ready = 1'b1;

    // Held reset with active inputs: outputs stay zero.
    rst = 1'b0;
    bus.in_i = 12'hAAA; bus.in_q = 12'hAAA; bus.in_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      chk("rst_hold", {bus.out, bus.out_valid, bus.overrun}, 0);
    end

    // Step responses.
    step_seq("step_i",       0, 0, 2047, 0, 1'b0, E_STEP_I);
    step_seq("step_i_qmask", 0, 0, 2047, 1, 1'b0, E_STEP_I);
    step_seq("step_iq",      0, 0, 2047, 1, 1'b1, E_STEP_IQ);
    step_seq("step_iq_neg",  0, 0, 2047, 2, 1'b1, E_STEP_IQ);
    // Full-scale swing, no wrap.
    step_seq("worst",        5, -2048, 2047, 1, 1'b1, E_WORST);

    // Handshake: hold, consume, then overrun.
    do_reset();
    bus.out_ready = 1'b0;
    send(100, 0, 1'b1, 1'b0);
    idle();
    for (int k = 0; k < 100; k++) begin
      if (k % 10 == 0) chk("hs_hold", bus.out_valid, 1);
      idle();
    end
    chk("hs_hold_end", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    idle();
    chk("hs_consume", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    send(200, 0, 1'b1, 1'b0);
    send(300, 0, 1'b1, 1'b0);
    ovr_cnt = 0;
    chk("ovr_first_vld", bus.out_valid, 1);
    if (bus.overrun) ovr_cnt++;
    for (int k = 0; k < 4; k++) begin
      idle();
      if (bus.overrun) ovr_cnt++;
    end
    chk("ovr_count", ovr_cnt, 1);
    chk("ovr_value", $signed(bus.out), -30000);
    chk("ovr_vld", bus.out_valid, 1);

    // Untriggered ramp, then triggered ramp, then gaps.
    do_reset();
    for (int j = 0; j < 50; j++) begin
      send(j, 0, 1'b0, 1'b0);
      if (j > 0 && j % 7 == 0) begin
        chk("ramp_notrig_out", $signed(bus.out), 0);
        chk("ramp_notrig_vld", bus.out_valid, 1);
      end
    end
    send(50, 0, 1'b1, 1'b0);
    chk("ramp_49", $signed(bus.out), 0);
    send(51, 0, 1'b1, 1'b0);
    chk("ramp_50", $signed(bus.out), -192);
    send(52, 0, 1'b1, 1'b0);
    chk("ramp_51", $signed(bus.out), -196);
    idle();
    chk("ramp_52", $signed(bus.out), -200);
    chk("ramp_52_vld", bus.out_valid, 1);
    idle();
    chk("gap_clear", bus.out_valid, 0);
    idle();
    chk("gap_hold", $signed(bus.out), -200);
    send(53, 0, 1'b1, 1'b0);
    idle();
    chk("gap_frozen", $signed(bus.out), -204);
    chk("gap_frozen_vld", bus.out_valid, 1);

    // Async reset with a sample in flight.
    do_reset();
    send(500, 500, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk("async_rst_vld", bus.out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_vld", bus.out_valid, 0);
    chk("post_rst_out", $signed(bus.out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
